// File: rtl/kill_detect_pkg.sv
// Shared game definitions: visible raster extents and the hit-emitter state set.
package kill_detect_pkg;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned V_VISIBLE_DEF = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } kd_state_e;

endpackage

// File: rtl/kill_detect_lowest_set.sv
// One-hot select of the lowest set bit of a request vector.
module lowest_set #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] req_i,
    output logic [W-1:0] grant_o
);

    // Two's-complement trick: req & -req isolates the least significant one.
    assign grant_o = req_i & (~req_i + W'(1));

endmodule

// File: rtl/kill_detect.sv
// Per-frame bullet/enemy hit detector; publishes a hit vector at frame end and
// serializes the hits into spaced single-cycle killed pulses.
module kill_detect
    import kill_detect_pkg::*;
#(
    parameter int unsigned N_ENEMIES = 4,
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           x,
    input  logic [8:0]           y,
    input  logic                 active,
    input  logic                 render_bullet,
    input  logic [N_ENEMIES-1:0] render_enemy,
    output logic [N_ENEMIES-1:0] enemy_hit,
    output logic                 killed,
    output logic                 busy
);

    kd_state_e              state_q, state_d;
    logic [N_ENEMIES-1:0]   acc_q, acc_d;
    logic [N_ENEMIES-1:0]   pend_q, pend_d;
    logic [N_ENEMIES-1:0]   hit_q, hit_d;
    logic [N_ENEMIES-1:0]   overlap, acc_next, emit_sel, clr_mask;
    logic                   fe_q, fe_px, frame_end;
    logic                   killed_q, killed_d;
    logic                   busy_q, busy_d;

    lowest_set #(
        .W(N_ENEMIES)
    ) u_lowest_set (
        .req_i  (pend_q),
        .grant_o(emit_sel)
    );

    always_comb begin
        overlap = '0;
        if (active && render_bullet && (32'(x) < H_VISIBLE) && (32'(y) < V_VISIBLE)) begin
            overlap = render_enemy;
        end
        fe_px     = (32'(x) == H_VISIBLE - 1) && (32'(y) == V_VISIBLE - 1);
        frame_end = fe_px & ~fe_q;
        // Overlap on the frame-end cycle itself belongs to the closing frame.
        acc_next  = acc_q | overlap;
        acc_d     = frame_end ? '0 : acc_next;
        hit_d     = frame_end ? acc_next : '0;

        state_d  = state_q;
        killed_d = 1'b0;
        clr_mask = '0;
        case (state_q)
            IDLE: if (|pend_q) state_d = EMIT;
            EMIT: begin
                killed_d = 1'b1;
                clr_mask = emit_sel;
                state_d  = GAP;
            end
            GAP:     state_d = (|pend_q) ? EMIT : IDLE;
            default: state_d = IDLE;
        endcase

        // Latch is ORed after the clear so a same-cycle re-hit is not lost.
        pend_d = (pend_q & ~clr_mask) | hit_d;
        busy_d = (state_d != IDLE) | (|pend_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            pend_q   <= '0;
            hit_q    <= '0;
            fe_q     <= 1'b0;
            killed_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            pend_q   <= pend_d;
            hit_q    <= hit_d;
            fe_q     <= fe_px;
            killed_q <= killed_d;
            busy_q   <= busy_d;
        end
    end

    assign enemy_hit = hit_q;
    assign killed    = killed_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_kill_detect.sv
// Bench for kill_detect: cycle-level behavioural model plus directed literal scenarios.
module tb_kill_detect;

    localparam int unsigned N = 4;
    localparam int unsigned H = 640;
    localparam int unsigned V = 480;

    logic         clk;
    logic         reset;
    logic [9:0]   x;
    logic [8:0]   y;
    logic         active;
    logic         render_bullet;
    logic [N-1:0] render_enemy;
    logic [N-1:0] enemy_hit;
    logic         killed;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    kill_detect #(
        .N_ENEMIES(N),
        .H_VISIBLE(H),
        .V_VISIBLE(V)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .active       (active),
        .render_bullet(render_bullet),
        .render_enemy (render_enemy),
        .enemy_hit    (enemy_hit),
        .killed       (killed),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending hits are a set of enemy indices; the emitter
    // "arms" one cycle after it sees work and fires one cycle after arming,
    // taking the smallest pending index.
    logic [N-1:0] m_acc, m_pend, m_eh;
    logic         m_armed, m_killed, m_fp_prev;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_acc     <= '0;
            m_pend    <= '0;
            m_eh      <= '0;
            m_armed   <= 1'b0;
            m_killed  <= 1'b0;
            m_fp_prev <= 1'b0;
        end else begin : model_step
            logic [N-1:0] ov;
            logic [N-1:0] closing;
            logic [N-1:0] pn;
            logic         fp;
            logic         fe;
            logic         found;
            ov = '0;
            if (active && render_bullet && int'(x) < int'(H) && int'(y) < int'(V)) ov = render_enemy;
            fp = (int'(x) == int'(H) - 1) && (int'(y) == int'(V) - 1);
            fe = fp && !m_fp_prev;
            closing = m_acc | ov;
            pn = m_pend;
            found = 1'b0;
            if (m_armed) begin
                for (int i = 0; i < int'(N); i++) begin
                    if (!found && pn[i]) begin
                        pn[i] = 1'b0;
                        found = 1'b1;
                    end
                end
            end
            if (fe) pn = pn | closing;
            m_pend    <= pn;
            m_eh      <= fe ? closing : '0;
            m_acc     <= fe ? '0 : closing;
            m_killed  <= m_armed;
            m_armed   <= !m_armed && (m_pend != '0);
            m_fp_prev <= fp;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_enemy_hit", 32'(enemy_hit), 32'(m_eh));
            check("model_killed", 32'(killed), 32'(m_killed));
            check("model_busy", 32'(busy), 32'(m_armed | m_killed | (m_pend != '0)));
        end
    end

    // Drive one cycle of inputs; returns just after the edge that sampled them.
    task automatic cyc(input int xx, input int yy, input logic a, input logic b, input logic [N-1:0] e);
        x             = 10'(xx);
        y             = 9'(yy);
        active        = a;
        render_bullet = b;
        render_enemy  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_count(input int n, output int kills);
        kills = 0;
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 1'b0, 1'b0, '0);
            kills += int'(killed);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] kv;
        logic [5:0] bv;
        int kc, kc2;

        reset = 1'b0;
        x = '0; y = '0; active = 1'b0; render_bullet = 1'b0; render_enemy = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_enemy_hit", 32'(enemy_hit), 32'h0);
        check("reset_killed", 32'(killed), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset  = 1'b1;
        cmp_en = 1'b1;
        idle_count(3, kc);

        // Single hit on enemy 2
        cyc(100, 50, 1'b1, 1'b1, 4'b0100);
        cyc(639, 479, 1'b1, 1'b0, 4'b0000);
        check("single_enemy_hit", 32'(enemy_hit), 32'h4);
        check("single_busy_e1", 32'(busy), 32'h1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1'b0, 1'b0, '0);
            kv[i] = killed;
            bv[i] = busy;
        end
        check("single_kill_pattern", 32'(kv[5:0]), 32'b000010);
        check("single_busy_pattern", 32'(bv), 32'b000011);

        // Multi hit on enemies 0,1,3
        idle_count(4, kc);
        cyc(10, 10, 1'b1, 1'b1, 4'b0011);
        cyc(20, 20, 1'b1, 1'b1, 4'b1000);
        cyc(639, 479, 1'b1, 1'b0, 4'b0000);
        check("multi_enemy_hit", 32'(enemy_hit), 32'hB);
        kv = '0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1'b0, 1'b0, '0);
            kv[i] = killed;
        end
        check("multi_kill_pattern", 32'(kv), 32'b0000101010);

        // Gating: inactive and off-screen overlaps are ignored
        idle_count(4, kc);
        cyc(100, 50, 1'b0, 1'b1, 4'b1111);
        cyc(700, 50, 1'b1, 1'b1, 4'b1111);
        cyc(100, 490, 1'b1, 1'b1, 4'b1111);
        cyc(639, 479, 1'b1, 1'b0, 4'b0000);
        check("gate_enemy_hit", 32'(enemy_hit), 32'h0);
        idle_count(8, kc);
        check("gate_kills", 32'(kc), 32'd0);

        // Boundary: overlap on the frame-end pixel, pixel held 4 cycles
        idle_count(4, kc);
        cyc(639, 479, 1'b1, 1'b1, 4'b0010);
        check("edge_enemy_hit", 32'(enemy_hit), 32'h2);
        kc = int'(killed);
        for (int i = 0; i < 3; i++) begin
            cyc(639, 479, 1'b1, 1'b0, 4'b0000);
            check("edge_hold_no_relatch", 32'(enemy_hit), 32'h0);
            kc += int'(killed);
        end
        idle_count(8, kc2);
        check("edge_kills", 32'(kc + kc2), 32'd1);

        // Re-latch of enemy 0 while its pulse is being emitted
        idle_count(4, kc);
        cyc(10, 10, 1'b1, 1'b1, 4'b0001);
        cyc(639, 479, 1'b1, 1'b0, 4'b0000);
        check("drain_enemy_hit_1", 32'(enemy_hit), 32'h1);
        cyc(0, 0, 1'b0, 1'b0, '0);
        cyc(639, 479, 1'b1, 1'b1, 4'b0001);
        check("drain_first_pulse", 32'(killed), 32'h1);
        check("drain_enemy_hit_2", 32'(enemy_hit), 32'h1);
        idle_count(8, kc);
        check("drain_total_kills", 32'(kc + 1), 32'd2);

        // Reset after the first of three pulses
        idle_count(4, kc);
        cyc(10, 10, 1'b1, 1'b1, 4'b0111);
        cyc(639, 479, 1'b1, 1'b0, 4'b0000);
        check("rst_enemy_hit", 32'(enemy_hit), 32'h7);
        cyc(0, 0, 1'b0, 1'b0, '0);
        cyc(0, 0, 1'b0, 1'b0, '0);
        check("rst_first_pulse", 32'(killed), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_killed_low", 32'(killed), 32'h0);
        check("rst_busy_low", 32'(busy), 32'h0);
        check("rst_enemy_hit_low", 32'(enemy_hit), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_count(10, kc);
        check("rst_no_more_kills", 32'(kc), 32'd0);
        check("rst_busy_after", 32'(busy), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            int xx, yy;
            r = int'($urandom_range(0, 7));
            if (r == 0) begin
                xx = int'(H) - 1; yy = int'(V) - 1;
            end else if (r == 1) begin
                xx = int'($urandom_range(600, 1023)); yy = int'($urandom_range(440, 511));
            end else begin
                xx = int'($urandom_range(0, 1023)); yy = int'($urandom_range(0, 511));
            end
            if ($urandom_range(0, 999) == 0) reset = 1'b0;
            cyc(xx, yy, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                N'($urandom_range(0, 15)));
            reset = 1'b1;
        end
        idle_count(12, kc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kill_detect.md
# kill_detect

Per-frame hit detector that produces the `killed` event stream consumed by the score block. It watches the bullet and enemy render strobes during the raster scan and records every enemy overlapped by a bullet pixel. At end of frame it publishes a one-cycle hit vector for enemy despawn, then serializes the hits into one-cycle `killed` pulses, one pulse per hit enemy.

## Interface
Parameters:
- N_ENEMIES, 4: number of enemy sprites, 1..16.
- H_VISIBLE, 640: visible columns. The last visible x is H_VISIBLE-1.
- V_VISIBLE, 480: visible rows. The last visible y is V_VISIBLE-1.

Ports:
- clk  in  1  system clock. One clock domain.
- reset  in  1  asynchronous, active-low reset.
- x  in  10  current raster column.
- y  in  9  current raster row.
- active  in  1  game running. While low, no new hits are recorded.
- render_bullet  in  1  a bullet pixel is at (x,y).
- render_enemy  in  N_ENEMIES  bit i set means enemy i has a pixel at (x,y).
- enemy_hit  out  N_ENEMIES  one-cycle pulse vector: enemies hit in the frame just ended.
- killed  out  1  one-cycle pulse per hit enemy. Drives the score `killed` input.
- busy  out  1  pending hits remain to be emitted.

## Operation
- Overlap condition for enemy i: `active & render_bullet & render_enemy[i] & x<H_VISIBLE & y<V_VISIBLE`.
- `hit_acc[i]` is a sticky bit. It sets on the cycle the overlap condition for enemy i is true.
- Frame end is the first cycle on which `x==H_VISIBLE-1 && y==V_VISIBLE-1`. It is edge-detected against a registered copy of that condition, so a held pixel counts once.
- On the frame-end cycle E:
  - An overlap occurring on cycle E is included.
  - `pending |= hit_acc_next` and `enemy_hit <= hit_acc_next` take effect at E+1.
  - `hit_acc` clears at E+1.
- FSM, with states IDLE, EMIT, GAP:
  - IDLE: if `pending != 0`, go to EMIT.
  - EMIT: assert `killed` for one cycle. Clear the lowest set bit of `pending`. Go to GAP.
  - GAP: `killed` is low for one cycle. If `pending != 0`, go to EMIT, else go to IDLE.
  - Pulses are emitted in ascending enemy index order, so k hits produce k pulses spaced 2 cycles apart.
- Simultaneous events:
  - If a frame-end latch and an EMIT clear hit the same bit in the same cycle, set wins. The enemy is counted again next pulse, so no hits are lost.
  - New hits OR into `pending` at any state.
- `busy = (state != IDLE) | (pending != 0)`.
- `active` low does not cancel already-pending pulses. Those still drain.
- Reset, asynchronous, at any time including mid-drain:
  - `hit_acc`, `pending`, and the edge register go to 0.
  - State goes to IDLE.
  - `enemy_hit` = 0, `killed` = 0, `busy` = 0.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Latency for the first hit:
  - `enemy_hit` asserts at E+1.
  - The first `killed` pulse asserts at E+3: latch at E+1, IDLE→EMIT at E+2, pulse registered at E+3.
- Worst-case drain is 2·N_ENEMIES+2 cycles. This is far below one frame, so `pending` cannot saturate in normal operation.
- Every `killed` pulse is exactly 1 cycle, with at least 1 low cycle between pulses. This matches the score counter's one-increment-per-high-cycle behaviour.

## Structure
- A shared game package holds:
  - the FSM state enum (IDLE, EMIT, GAP);
  - the H_VISIBLE/V_VISIBLE defaults, shared with the renderers.
- Sub-module `lowest_set`: parameterised one-hot priority select of the lowest set bit, used to clear `pending`.
- The frame-end edge detector stays inline.

## Test plan
- Single hit: overlap enemy 2 at (100,50) with N=4 → `enemy_hit=4'b0100` at E+1, exactly one `killed` pulse at E+3, `busy` low by E+5.
- Multi hit: overlaps on enemies 0, 1, and 3 in one frame → `enemy_hit=4'b1011`, three `killed` pulses at E+3, E+5, E+7, score increments by 3.
- Gating: overlap while `active=0` → `enemy_hit=0`, no `killed` pulses. Overlap at x=700 (off-screen) is also ignored.
- Boundary: overlap exactly on frame-end pixel (639,479) → counted in that frame. Pixel held 4 cycles → exactly one latch.
- Overlap during drain: frame end re-latches enemy 0 while its pulse is in EMIT → an extra pulse follows, total pulse count equals total hits.
- Reset mid-drain: assert reset after the first of three pulses → `killed`, `busy`, and `enemy_hit` go low immediately, and no further pulses occur after release.
